// File: rtl/data_mem_resp_pkg.sv
// Shared widths, MMIO register offsets and the byte-lane merge helper for the
// data-memory responder.
package data_mem_resp_pkg;

    localparam int unsigned DATA_BUS      = 32;
    localparam int unsigned DATA_ADDR_BUS = 32;
    localparam int unsigned DATA_WE_BUS   = 4;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hBFAF_0000;

    localparam logic [15:0] LED_OFS   = 16'h0000;
    localparam logic [15:0] CYCLE_OFS = 16'h0004;
    localparam logic [15:0] TCMP_OFS  = 16'h0008;
    localparam logic [15:0] TSTAT_OFS = 16'h000C;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [DATA_BUS-1:0] byte_merge(
        input logic [DATA_BUS-1:0]    old_data,
        input logic [DATA_BUS-1:0]    new_data,
        input logic [DATA_WE_BUS-1:0] be
    );
        logic [DATA_BUS-1:0] merged;
        merged = old_data;
        for (int i = 0; i < DATA_WE_BUS; i++) begin
            if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised synchronous RAM with four byte-lane write enables and a
// registered read port that updates only on read cycles.
module dmem_ram
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [DATA_WE_BUS-1:0]   we,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [DATA_BUS-1:0]      din,
    output logic [DATA_BUS-1:0]      dout
);

    logic [DATA_BUS-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; only the
    // read register below is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WE_BUS; i++) begin
            if (en && we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
    end

    // NOTE: state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (en && we == '0) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Responder end of the CPU data-memory port: byte-writable RAM plus, when
// DMEM_MMIO_EN is defined, an MMIO window with LED, cycle counter and timer.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE,
    parameter int unsigned LED_WIDTH  = 16
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst_n,
    input  logic                     dce,
    input  logic [DATA_ADDR_BUS-1:0] daddr,
    input  logic [DATA_WE_BUS-1:0]   we,
    input  logic [DATA_BUS-1:0]      din,
    output logic [DATA_BUS-1:0]      dm,
    output logic [LED_WIDTH-1:0]     led_o,
    output logic                     timer_irq
);

    logic                   ram_en;
    logic [DATA_WE_BUS-1:0] ram_we;
    logic [DATA_BUS-1:0]    ram_dout;

    // Writes are gated while reset is held so an interrupted store never lands.
    assign ram_we = (ram_en && cpu_rst_n) ? we : '0;

    dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (daddr[ADDR_WIDTH+1:2]),
        .din   (din),
        .dout  (ram_dout)
    );

`ifdef DMEM_MMIO_EN
    logic                 in_window;
    logic                 mmio_rd;
    logic                 mmio_wr;
    logic [15:0]          ofs;
    logic [LED_WIDTH-1:0] led_q;
    logic [31:0]          cycle_cnt;
    logic [31:0]          tcmp;
    logic                 flag;
    logic                 timer_match;
    logic                 flag_clr;
    logic [31:0]          mmio_rdata;
    logic [31:0]          mmio_q;
    logic                 src_mmio;
    logic                 unused_bits;

    assign in_window   = (daddr[31:16] == MMIO_BASE[31:16]);
    assign ram_en      = dce && !in_window;
    assign mmio_rd     = dce && in_window && (we == '0);
    assign mmio_wr     = dce && in_window && (we != '0);
    assign ofs         = {daddr[15:2], 2'b00};
    assign timer_match = (cycle_cnt == tcmp) && (tcmp != '0);
    assign flag_clr    = mmio_wr && (ofs == TSTAT_OFS) && we[0] && din[0];
    assign unused_bits = &{1'b0, daddr[1:0], MMIO_BASE[15:0]};

    // NOTE: the default before the case keeps this purely combinational.
    always_comb begin
        mmio_rdata = '0;
        case (ofs)
            LED_OFS:   mmio_rdata = 32'(led_q);
            CYCLE_OFS: mmio_rdata = cycle_cnt;
            TCMP_OFS:  mmio_rdata = tcmp;
            TSTAT_OFS: mmio_rdata = {31'b0, flag};
            default:   mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            led_q     <= '0;
            cycle_cnt <= '0;
            tcmp      <= '0;
            flag      <= 1'b0;
            mmio_q    <= '0;
            src_mmio  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (mmio_rd) mmio_q <= mmio_rdata;
            if (dce && we == '0) src_mmio <= in_window;
            if (mmio_wr && ofs == LED_OFS)
                led_q <= LED_WIDTH'(byte_merge(32'(led_q), din, we));
            if (mmio_wr && ofs == TCMP_OFS)
                tcmp <= byte_merge(tcmp, din, we);
            // A match on the same edge as a clear wins.
            if (timer_match)   flag <= 1'b1;
            else if (flag_clr) flag <= 1'b0;
        end
    end

    assign dm        = src_mmio ? mmio_q : ram_dout;
    assign led_o     = led_q;
    assign timer_irq = flag;
`else
    logic unused_bits;

    assign ram_en      = dce;
    assign unused_bits = &{1'b0, daddr[1:0], daddr[DATA_ADDR_BUS-1:ADDR_WIDTH+2], MMIO_BASE};
    assign dm          = ram_dout;
    assign led_o       = '0;
    assign timer_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed accesses, a per-cycle
// behavioural model comparison, and hand-computed spot checks.
module tb_data_mem_resp;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dce   = 1'b0;
    logic [31:0] daddr = '0;
    logic [3:0]  we    = '0;
    logic [31:0] din   = '0;
    logic [31:0] dm;
    logic [15:0] led_o;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_resp dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .dce         (dce),
        .daddr       (daddr),
        .we          (we),
        .din         (din),
        .dm          (dm),
        .led_o       (led_o),
        .timer_irq   (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: memory as a word array, registers as plain variables.
    logic [31:0] m_mem [8192];
    logic [31:0] m_dm   = '0;
    logic [15:0] m_led  = '0;
    logic [31:0] m_cnt  = '0;
    logic [31:0] m_tcmp = '0;
    logic        m_flag = 1'b0;
    logic        m_hit;
    logic [15:0] m_ofs;
    logic [12:0] m_idx;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_dm = '0; m_led = '0; m_cnt = '0; m_tcmp = '0; m_flag = 1'b0;
            end else begin
                m_hit = (m_tcmp != 0) && (m_cnt == m_tcmp);
                if (dce) begin
                    m_ofs = {daddr[15:2], 2'b00};
                    m_idx = daddr[14:2];
                    if (MMIO && daddr[31:16] == 16'hBFAF) begin
                        if (we == 4'b0000) begin
                            case (m_ofs)
                                16'h0:   m_dm = {16'h0, m_led};
                                16'h4:   m_dm = m_cnt;
                                16'h8:   m_dm = m_tcmp;
                                16'hC:   m_dm = {31'h0, m_flag};
                                default: m_dm = '0;
                            endcase
                        end else begin
                            for (int b = 0; b < 4; b++) begin
                                if (we[b] && m_ofs == 16'h0 && b < 2) m_led[8*b +: 8] = din[8*b +: 8];
                                if (we[b] && m_ofs == 16'h8) m_tcmp[8*b +: 8] = din[8*b +: 8];
                            end
                            if (m_ofs == 16'hC && we[0] && din[0]) m_flag = 1'b0;
                        end
                    end else if (we == 4'b0000) begin
                        m_dm = m_mem[m_idx];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (we[b]) m_mem[m_idx][8*b +: 8] = din[8*b +: 8];
                    end
                end
                if (m_hit) m_flag = 1'b1;
                m_cnt = m_cnt + 1;
            end
            #1;
            if (!$isunknown(m_dm)) check("model_dm", dm, m_dm);
            check("model_led", {16'h0, led_o}, {16'h0, m_led});
            check("model_irq", {31'h0, timer_irq}, {31'h0, m_flag});
        end
    end

    task automatic access(input logic c, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        dce = c; daddr = a; we = w; din = d;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] LED_A   = 32'hBFAF_0000;
    localparam logic [31:0] CYC_A   = 32'hBFAF_0004;
    localparam logic [31:0] TCMP_A  = 32'hBFAF_0008;
    localparam logic [31:0] TSTAT_A = 32'hBFAF_000C;

    logic [31:0] c0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_dm", dm, 32'h0);
        check("reset_led", {16'h0, led_o}, 32'h0);
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        rst_n = 1'b1;

        access(1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
        access(1, 32'h0000_0010, 4'b0000, 32'h0);
        check("full_write_read", dm, 32'hDEAD_BEEF);

        access(1, 32'h0000_0010, 4'b0010, 32'h0000_5500);
        check("write_holds_dm", dm, 32'hDEAD_BEEF);
        access(1, 32'h0000_0010, 4'b0000, 32'h0);
        check("partial_store", dm, 32'hDEAD_55EF);
        access(1, 32'h0000_0013, 4'b0000, 32'h0);
        check("low_bits_ignored", dm, 32'hDEAD_55EF);

        for (int i = 0; i < 3; i++) begin
            access(0, 32'h0000_0010, 4'b0000, 32'h0);
            check("idle_hold", dm, 32'hDEAD_55EF);
        end
        access(1, 32'h0000_0020, 4'b1111, 32'h1234_5678);
        check("write_hold", dm, 32'hDEAD_55EF);
        access(1, 32'h0000_0020, 4'b0000, 32'h0);
        check("second_word", dm, 32'h1234_5678);

        access(1, 32'h0000_8010, 4'b1111, 32'h0BAD_F00D);
        access(1, 32'h0000_0010, 4'b0000, 32'h0);
        check("alias_wrap", dm, 32'h0BAD_F00D);

`ifdef DMEM_MMIO_EN
        access(1, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D);
        access(1, LED_A, 4'b1111, 32'h0000_A5A5);
        check("led_write", {16'h0, led_o}, 32'h0000_A5A5);
        access(1, 32'h0000_0000, 4'b0000, 32'h0);
        check("ram_untouched", dm, 32'hCAFE_F00D);
        access(1, LED_A, 4'b0001, 32'hFFFF_FFFF);
        check("led_byte_en", {16'h0, led_o}, 32'h0000_A5FF);
        access(1, LED_A, 4'b0000, 32'h0);
        check("led_read", dm, 32'h0000_A5FF);
        access(1, 32'hBFAF_0010, 4'b0000, 32'h0);
        check("unmapped_read", dm, 32'h0);

        access(1, CYC_A, 4'b0000, 32'h0);
        c0 = dm;
        repeat (4) access(0, 32'h0, 4'b0000, 32'h0);
        access(1, CYC_A, 4'b0000, 32'h0);
        check("cycle_delta", dm - c0, 32'd5);

        access(1, CYC_A, 4'b0000, 32'h0);
        c0 = dm;
        access(1, TCMP_A, 4'b1111, c0 + 32'd20);
        repeat (18) access(0, 32'h0, 4'b0000, 32'h0);
        check("timer_not_yet", {31'h0, timer_irq}, 32'h0);
        access(0, 32'h0, 4'b0000, 32'h0);
        check("timer_fired", {31'h0, timer_irq}, 32'h1);
        access(1, TSTAT_A, 4'b0000, 32'h0);
        check("tstat_read", dm, 32'h1);
        access(1, TSTAT_A, 4'b0001, 32'h1);
        check("w1c_clear", {31'h0, timer_irq}, 32'h0);

        access(1, CYC_A, 4'b0000, 32'h0);
        c0 = dm;
        access(1, TCMP_A, 4'b1111, c0 + 32'd3);
        access(0, 32'h0, 4'b0000, 32'h0);
        access(1, TSTAT_A, 4'b0001, 32'h1);
        check("set_beats_w1c", {31'h0, timer_irq}, 32'h1);
        access(1, TSTAT_A, 4'b0001, 32'h1);
        check("later_w1c", {31'h0, timer_irq}, 32'h0);
`else
        access(1, 32'hBFAF_0010, 4'b1111, 32'h600D_CAFE);
        access(1, 32'h0000_0010, 4'b0000, 32'h0);
        check("no_mmio_alias", dm, 32'h600D_CAFE);
        check("led_const", {16'h0, led_o}, 32'h0);
`endif

        access(1, 32'h0000_0040, 4'b1111, 32'h1111_1111);
        access(1, 32'h0000_0040, 4'b0000, 32'h0);
        check("pre_reset_read", dm, 32'h1111_1111);
        dce = 1'b1; daddr = 32'h0000_0040; we = 4'b1111; din = 32'h2222_2222;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_dm", dm, 32'h0);
        check("async_rst_led", {16'h0, led_o}, 32'h0);
        check("async_rst_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dce = 1'b0; we = 4'b0000;
`ifdef DMEM_MMIO_EN
        access(1, CYC_A, 4'b0000, 32'h0);
        check("cycle_after_reset", dm, 32'h0);
`endif
        access(1, 32'h0000_0040, 4'b0000, 32'h0);
        check("aborted_write", dm, 32'h1111_1111);

        repeat (2) access(0, 32'h0, 4'b0000, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Responder (slave) end of the CPU data-memory port: accepts `daddr`/`dce`/`we`/`din` from the core and returns `dm`.
- Provides a word-organised, byte-writable synchronous data RAM.
- Read data is registered, so it is valid in the cycle after the request, matching the core's MEM→WB load timing.
- Optionally decodes a small MMIO window: LED register, free-running cycle counter and a compare timer with a sticky interrupt flag.

Parameters:
- ADDR_WIDTH, 13, word-address bits of the RAM (2^13 words = 32 KiB).
- MMIO_BASE, 32'hBFAF_0000, base of the MMIO window; compared on `daddr[31:16]`.
- LED_WIDTH, 16, width of the LED register/output.

Ports:
- cpu_clk_50M  in  1  system clock; all state updates on the rising edge.
- cpu_rst_n  in  1  asynchronous, active-low reset.
- dce  in  1  access enable for the current cycle.
- daddr  in  32  byte address; `[1:0]` ignored (word access only).
- we  in  4  byte write enables; `we[i]` writes `din[8i+7:8i]`; 4'b0000 with `dce` = read.
- din  in  32  store data, little-endian byte lanes.
- dm  out  32  registered read data.
- led_o  out  LED_WIDTH  LED register contents.
- timer_irq  out  1  level interrupt = sticky match flag.

Behaviour:
- **Reset (async, cpu_rst_n=0):**
  - `dm`=0, `led_o`=0, cycle counter=0, TCMP=0, flag=0.
  - RAM contents are not reset.
  - Reset mid-access aborts it; no partial write lands.
- **Read:** `dce`=1, `we`=0 at edge N → `dm` holds `mem[daddr[ADDR_WIDTH+1:2]]` after edge N. One cycle latency.
- **Write:** `dce`=1, `we`≠0 at edge N → enabled lanes updated at edge N; disabled lanes unchanged.
  - `dm` holds its previous value on a write cycle.
- **Idle:** `dce`=0 → no state change; `dm` holds.
- **Back-to-back:** a write at edge N followed by a read of the same word at edge N+1 returns the new data.
  - Only one access per cycle exists, so no same-cycle hazard.
- **Address wrap:** RAM index uses only the low ADDR_WIDTH word bits; higher bits alias (outside the MMIO window).
- **Cycle counter:** increments every cycle after reset; wraps 0xFFFF_FFFF→0.
- **MMIO map** (`daddr[15:0]` word offsets, active only inside the window):
  - 0x0 LED: RW, low LED_WIDTH bits, byte-enable honoured; upper read bits return 0.
  - 0x4 CYCLE: RO, returns the counter value present in the request cycle; writes ignored.
  - 0x8 TCMP: RW, byte-enable honoured.
  - 0xC TSTAT: bit0 = flag; writing 1 to bit0 (with `we[0]`) clears it; other bits read 0.
  - Other offsets: reads return 0, writes ignored.
- **Timer match:** flag set at the edge where counter==TCMP and TCMP≠0.
  - Simultaneous set and W1C → set wins.
  - `timer_irq` = flag.
- MMIO accesses never touch the RAM.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- **Defined:** window decoded as above; `led_o`/`timer_irq` driven from the registers.
- **Undefined:** every address maps to RAM by its low bits; counter, TCMP and flag are not instantiated; `led_o`=0 and `timer_irq`=0 constant.

Decomposition:
- Shared package/defines: MMIO offset constants (LED_OFS, CYCLE_OFS, TCMP_OFS, TSTAT_OFS), MMIO_BASE default, and the existing `DATA_BUS`/`DATA_ADDR_BUS`/`DATA_WE_BUS` widths.
- One sub-module, `dmem_ram`: 2^ADDR_WIDTH × 32 synchronous RAM with 4 byte-lane write enables and a registered read port.
- MMIO registers and output mux stay in `data_mem_resp`.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010 with `we`=4'b1111, then read 0x10 next cycle → `dm`=0xDEADBEEF one cycle after the read request.
- Partial store: `we`=4'b0010, `din`=0x0000_5500 to the same word, then read → `dm`=0xDEAD55EF; read of 0x0000_0013 returns the same word.
- Idle/write hold: after a read returns 0xDEAD55EF, drive `dce`=0 for 3 cycles, then a write → `dm` stays 0xDEAD55EF throughout.
- MMIO (DMEM_MMIO_EN): write 0x0000_A5A5 to LED → `led_o`=16'hA5A5, RAM word 0 unchanged; two CYCLE reads 5 cycles apart differ by 5.
- Timer: write TCMP = current count+20 → `timer_irq` rises exactly 20 cycles after that count; W1C in the same cycle as a new match leaves flag=1; a later W1C → 0.
- Assert cpu_rst_n=0 mid-write burst → `dm`, `led_o`, counter, flag read 0 immediately (async); the aborted write is not observed.
